// File: rtl/can_clic_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// can_clic_dispatch_pkg
//   Shared types for the can_clic arbiter and its downstream dispatch stage.
//   Entries : one PRIO_WIDTH priority per entry. The highest entry
//             (THRESHOLD_INDEX) carries the running threshold.
//   Index   : entry / source index.
//   Prio    : one priority value.
//   SrcMask : one bit per interrupt source (entries below the threshold slot).
//   dispatch_state_e : states of the dispatch request FSM.
// ----------------------------------------------------------------------------
package can_clic_dispatch_pkg;

    localparam int unsigned NR_ENTRIES      = 4;
    localparam int unsigned PRIO_WIDTH      = 3;
    localparam int unsigned THRESHOLD_INDEX = NR_ENTRIES - 1;
    // Every slot below the threshold slot is an interrupt source.
    localparam int unsigned NR_SOURCES      = THRESHOLD_INDEX;
    localparam int unsigned INDEX_WIDTH     = $clog2(NR_ENTRIES);

    typedef logic [PRIO_WIDTH-1:0]                  Prio;
    typedef logic [NR_ENTRIES-1:0][PRIO_WIDTH-1:0]  Entries;
    typedef logic [INDEX_WIDTH-1:0]                 Index;
    typedef logic [NR_SOURCES-1:0]                  SrcMask;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } dispatch_state_e;

    // One-hot source mask; an id outside the source range yields all zeros.
    function automatic SrcMask src_onehot(Index id);
        SrcMask mask;
        mask = '0;
        for (int i = 0; i < NR_SOURCES; i++) begin
            if (Index'(i) == id) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/can_clic_prio_stack.sv
// ----------------------------------------------------------------------------
// can_clic_prio_stack
//   LIFO of saved thresholds used for interrupt nesting.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push       : store push_data on top (ignored when full unless popping)
//     pop        : discard the top entry (ignored when empty)
//     push_data  : value to push
//     top        : current top entry (0 when empty)
//     depth      : number of stored entries
//     full/empty : depth == DEPTH / depth == 0
//   A simultaneous push and pop overwrites the top slot in place, so depth
//   does not change.
// ----------------------------------------------------------------------------
module can_clic_prio_stack
    import can_clic_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  Prio                          push_data,
    output Prio                          top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    Prio           mem [DEPTH];
    logic          do_pop;
    logic          do_push;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;

    assign empty   = (depth == '0);
    assign full    = (depth == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign top_idx = AW'(depth - CW'(1));
    assign wr_idx  = do_pop ? top_idx : AW'(depth);
    assign top     = empty ? '0 : mem[top_idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
            // NOTE: the storage is small and observable contents are required
            // to be 0 after reset, so it is cleared like ordinary flops.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) mem[wr_idx] <= push_data;
            if (do_push && !do_pop)      depth <= depth + CW'(1);
            else if (do_pop && !do_push) depth <= depth - CW'(1);
        end
    end

endmodule

// File: rtl/can_clic_dispatch.sv
// ----------------------------------------------------------------------------
// can_clic_dispatch
//   Sequential dispatch stage behind the combinational can_clic arbiter.
//   Turns an arbitration win into a req/ack handshake with the core, raises
//   the running threshold to the taken priority (saving the old one on a
//   nesting stack), pulses a one-hot pending-clear for the taken source and
//   restores the previous threshold on return-from-interrupt.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     entries_i      : entries vector also presented to can_clic
//     is_interrupt_i : can_clic has a winner
//     index_i        : can_clic winner index
//     irq_req_o      : request to core (registered)
//     irq_id_o       : source id of the request (registered)
//     irq_ack_i      : core accepts the request
//     ret_i          : one-cycle return-from-handler pulse
//     thr_we_i       : software threshold write strobe
//     thr_wdata_i    : software threshold value
//     threshold_o    : running threshold, feeds can_clic slot THRESHOLD_INDEX
//     pend_clr_o     : one-hot pending-clear pulse for the taken source
//     depth_o        : current nesting depth
//     stack_err_o    : sticky stack over/underflow flag (only with
//                      CAN_CLIC_STACK_ERR_EN defined)
//   Optional feature macro: CAN_CLIC_STACK_ERR_EN.
// ----------------------------------------------------------------------------
module can_clic_dispatch
    import can_clic_dispatch_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  Entries                             entries_i,
    input  logic                               is_interrupt_i,
    input  Index                               index_i,
    output logic                               irq_req_o,
    output Index                               irq_id_o,
    input  logic                               irq_ack_i,
    input  logic                               ret_i,
    input  logic                               thr_we_i,
    input  logic [PRIO_WIDTH-1:0]              thr_wdata_i,
    output logic [PRIO_WIDTH-1:0]              threshold_o,
    output logic [NR_ENTRIES-2:0]              pend_clr_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o
`ifdef CAN_CLIC_STACK_ERR_EN
    ,
    output logic                               stack_err_o
`endif
);

    dispatch_state_e state_q;
    Prio             prio_q;       // priority latched with the request
    Prio             stk_top;
    Prio             stk_push_data;
    logic            stk_full;
    logic            stk_empty;
    logic            take;
    logic            ret_pop;

    assign take    = (state_q == ST_REQ) && irq_ack_i;
    assign ret_pop = ret_i && !stk_empty;

    // Tail-chain (ret and ack together): the value pushed is the one being
    // popped, so the stack contents and depth end up unchanged.
    assign stk_push_data = ret_pop ? stk_top : threshold_o;

    can_clic_prio_stack #(
        .DEPTH     (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (take),
        .pop       (ret_i),
        .push_data (stk_push_data),
        .top       (stk_top),
        .depth     (depth_o),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            irq_req_o   <= 1'b0;
            irq_id_o    <= '0;
            prio_q      <= '0;
            pend_clr_o  <= '0;
            threshold_o <= '0;
        end else begin
            pend_clr_o <= '0;

            // Threshold priority: ack > effective return > software write.
            if (take)          threshold_o <= prio_q;
            else if (ret_pop)  threshold_o <= stk_top;
            else if (thr_we_i) threshold_o <= thr_wdata_i;

            case (state_q)
                ST_IDLE: begin
                    // can_clic has already compared against the threshold,
                    // so the winner is taken without a priority recheck.
                    if (is_interrupt_i && !stk_full) begin
                        irq_id_o  <= index_i;
                        prio_q    <= entries_i[index_i];
                        irq_req_o <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Request is held stable until acknowledged.
                    if (irq_ack_i) begin
                        irq_req_o  <= 1'b0;
                        pend_clr_o <= src_onehot(irq_id_o);
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    irq_req_o <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CAN_CLIC_STACK_ERR_EN
    // A new error in the same cycle as a software write wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_err_o <= 1'b0;
        end else if ((ret_i && stk_empty) ||
                     ((state_q == ST_IDLE) && is_interrupt_i && stk_full)) begin
            stack_err_o <= 1'b1;
        end else if (thr_we_i) begin
            stack_err_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_can_clic_dispatch.sv
module tb_can_clic_dispatch;
    import can_clic_dispatch_pkg::*;

    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned DW          = $clog2(STACK_DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    Entries          entries;
    logic            is_int;
    Index            index;
    logic            irq_req;
    Index            irq_id;
    logic            ack;
    logic            ret;
    logic            we;
    Prio             wd;
    Prio             thr;
    SrcMask          pclr;
    logic [DW-1:0]   depth;
`ifdef CAN_CLIC_STACK_ERR_EN
    logic            stack_err;
`endif

    always #5 clk = ~clk;

    can_clic_dispatch #(
        .STACK_DEPTH    (STACK_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .entries_i      (entries),
        .is_interrupt_i (is_int),
        .index_i        (index),
        .irq_req_o      (irq_req),
        .irq_id_o       (irq_id),
        .irq_ack_i      (ack),
        .ret_i          (ret),
        .thr_we_i       (we),
        .thr_wdata_i    (wd),
        .threshold_o    (thr),
        .pend_clr_o     (pclr),
        .depth_o        (depth)
`ifdef CAN_CLIC_STACK_ERR_EN
        ,
        .stack_err_o    (stack_err)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input Index e_id,
                              input Prio e_thr, input logic [DW-1:0] e_dep, input SrcMask e_pclr);
        check({tag, ".irq_req"},   32'(irq_req), 32'(e_req));
        check({tag, ".irq_id"},    32'(irq_id),  32'(e_id));
        check({tag, ".threshold"}, 32'(thr),     32'(e_thr));
        check({tag, ".depth"},     32'(depth),   32'(e_dep));
        check({tag, ".pend_clr"},  32'(pclr),    32'(e_pclr));
    endtask

    function automatic Entries ent(input int p2, input int p1, input int p0);
        Entries e;
        e    = '0;
        e[2] = Prio'(p2);
        e[1] = Prio'(p1);
        e[0] = Prio'(p0);
        return e;
    endfunction

    task automatic drive(input logic i_int, input Index i_idx, input Entries i_ent,
                         input logic i_ack, input logic i_ret, input logic i_we, input Prio i_wd);
        is_int  = i_int;
        index   = i_idx;
        entries = i_ent;
        ack     = i_ack;
        ret     = i_ret;
        we      = i_we;
        wd      = i_wd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic          is_int;
        Index          idx;
        Entries        ent;
        logic          ack;
        logic          ret;
        logic          we;
        Prio           wd;
        logic          e_req;
        Index          e_id;
        Prio           e_thr;
        logic [DW-1:0] e_dep;
        SrcMask        e_pclr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic i_int, input int i_idx, input Entries i_ent,
                                 input logic i_ack, input logic i_ret, input logic i_we, input int i_wd,
                                 input logic e_req, input int e_id, input int e_thr,
                                 input int e_dep, input int e_pclr);
        vec_t v;
        v.is_int = i_int;        v.idx    = Index'(i_idx);  v.ent = i_ent;
        v.ack    = i_ack;        v.ret    = i_ret;          v.we  = i_we;
        v.wd     = Prio'(i_wd);  v.e_req  = e_req;          v.e_id = Index'(e_id);
        v.e_thr  = Prio'(e_thr); v.e_dep  = DW'(e_dep);     v.e_pclr = SrcMask'(e_pclr);
        return v;
    endfunction

    // ------------------------------------------------------------ ref model
    // Abstract view: a pending request (id, prio), a threshold and a queue of
    // saved thresholds.
    bit     m_req;
    int     m_id;
    int     m_prio;
    int     m_thr;
    int     m_pclr;
    int     m_stk[$];
`ifdef CAN_CLIC_STACK_ERR_EN
    bit     m_err;
`endif

    task automatic model_reset();
        m_req  = 1'b0;
        m_id   = 0;
        m_prio = 0;
        m_thr  = 0;
        m_pclr = 0;
        m_stk.delete();
`ifdef CAN_CLIC_STACK_ERR_EN
        m_err  = 1'b0;
`endif
    endtask

    task automatic model_step();
        int sz;
        bit take;
        bit popping;
        int v;
        int nthr;
        sz      = m_stk.size();
        take    = m_req && ack;
        popping = ret && (sz > 0);
        v       = 0;
        nthr    = m_thr;
        m_pclr  = 0;
        if (popping) v = m_stk.pop_back();
        if (take)         nthr = m_prio;
        else if (popping) nthr = v;
        else if (we)      nthr = int'(wd);
        if (take) m_stk.push_back(popping ? v : m_thr);
`ifdef CAN_CLIC_STACK_ERR_EN
        if ((ret && sz == 0) || (!m_req && is_int && sz == STACK_DEPTH)) m_err = 1'b1;
        else if (we) m_err = 1'b0;
`endif
        if (take) begin
            m_req  = 1'b0;
            m_pclr = 1 << m_id;
        end else if (!m_req && is_int && sz < STACK_DEPTH) begin
            m_req  = 1'b1;
            m_id   = int'(index);
            m_prio = int'(entries[index]);
        end
        m_thr = nthr;
    endtask

    // ----------------------------------------------------------------- test
    initial begin
        Entries e1;
        Entries e2;
        Entries e3;
        e1 = ent(3, 2, 1);
        e2 = ent(3, 2, 6);
        e3 = ent(3, 5, 1);

        //               int idx ent ack ret we wd   req id thr dep pclr
        tbl.push_back(mkv(1, 2, e1, 0, 0, 0, 0,     1, 2, 0, 0, 0));  // basic take: request
        tbl.push_back(mkv(1, 0, e1, 0, 0, 0, 0,     1, 2, 0, 0, 0));  // held, not replaced
        tbl.push_back(mkv(0, 0, e1, 1, 0, 0, 0,     0, 2, 3, 1, 4));  // ack
        tbl.push_back(mkv(0, 0, e1, 0, 0, 0, 0,     0, 2, 3, 1, 0));  // clear pulse gone
        tbl.push_back(mkv(1, 0, e2, 0, 0, 0, 0,     1, 0, 3, 1, 0));  // nest prio 6
        tbl.push_back(mkv(0, 0, e2, 1, 0, 0, 0,     0, 0, 6, 2, 1));
        tbl.push_back(mkv(0, 0, e2, 0, 1, 0, 0,     0, 0, 3, 1, 0));  // ret
        tbl.push_back(mkv(0, 0, e2, 0, 1, 0, 0,     0, 0, 0, 0, 0));  // ret
        tbl.push_back(mkv(0, 0, e2, 0, 1, 0, 0,     0, 0, 0, 0, 0));  // underflow
        tbl.push_back(mkv(0, 0, e2, 0, 0, 1, 2,     0, 0, 2, 0, 0));  // thr write
        tbl.push_back(mkv(0, 0, e2, 0, 0, 1, 0,     0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 2, e1, 0, 0, 0, 0,     1, 2, 0, 0, 0));  // tail-chain setup
        tbl.push_back(mkv(0, 0, e1, 1, 0, 0, 0,     0, 2, 3, 1, 4));
        tbl.push_back(mkv(1, 1, e3, 0, 0, 0, 0,     1, 1, 3, 1, 0));
        tbl.push_back(mkv(0, 0, e3, 1, 1, 0, 0,     0, 1, 5, 1, 2));  // ret + ack
        tbl.push_back(mkv(0, 0, e3, 0, 1, 0, 0,     0, 1, 0, 0, 0));  // top was 0
        tbl.push_back(mkv(0, 0, e3, 0, 0, 1, 1,     0, 1, 1, 0, 0));
        tbl.push_back(mkv(1, 2, e1, 0, 0, 0, 0,     1, 2, 1, 0, 0));
        tbl.push_back(mkv(0, 0, e1, 1, 0, 1, 7,     0, 2, 3, 1, 4));  // ack beats write
        tbl.push_back(mkv(0, 0, e1, 0, 1, 1, 7,     0, 2, 1, 0, 0));  // ret beats write
        tbl.push_back(mkv(0, 0, e1, 1, 0, 1, 0,     0, 2, 0, 0, 0));  // ack in IDLE ignored

        // Reset state
        do_reset();
        check_outs("reset", 1'b0, '0, '0, '0, '0);

        // Table vectors
        foreach (tbl[i]) begin
            drive(tbl[i].is_int, tbl[i].idx, tbl[i].ent, tbl[i].ack, tbl[i].ret, tbl[i].we, tbl[i].wd);
            tick();
            check_outs($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_id, tbl[i].e_thr,
                       tbl[i].e_dep, tbl[i].e_pclr);
        end

        // Stack full: four nested takes, then a higher winner is ignored
        do_reset();
        for (int p = 1; p <= 4; p++) begin
            drive(1'b1, Index'(0), ent(0, 0, p), 1'b0, 1'b0, 1'b0, '0);
            tick();
            check_outs($sformatf("full_req%0d", p), 1'b1, Index'(0), Prio'(p - 1), DW'(p - 1), '0);
            drive(1'b0, Index'(0), ent(0, 0, p), 1'b1, 1'b0, 1'b0, '0);
            tick();
            check_outs($sformatf("full_ack%0d", p), 1'b0, Index'(0), Prio'(p), DW'(p), SrcMask'(1));
        end
        drive(1'b1, Index'(1), ent(0, 5, 0), 1'b0, 1'b0, 1'b0, '0);
        tick();
        check_outs("full_block0", 1'b0, Index'(0), Prio'(4), DW'(4), '0);
        tick();
        check_outs("full_block1", 1'b0, Index'(0), Prio'(4), DW'(4), '0);
`ifdef CAN_CLIC_STACK_ERR_EN
        check("full_stack_err", 32'(stack_err), 32'(1));
`endif
        for (int k = 3; k >= 0; k--) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
            tick();
            check_outs($sformatf("full_ret%0d", k), 1'b0, Index'(0), Prio'(k), DW'(k), '0);
        end
`ifdef CAN_CLIC_STACK_ERR_EN
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
        tick();
        check("err_cleared", 32'(stack_err), 32'(0));
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        check("err_underflow", 32'(stack_err), 32'(1));
`endif

        // Async reset during REQ takes effect without a clock edge
        do_reset();
        drive(1'b1, Index'(2), e1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        drive(1'b0, Index'(2), e1, 1'b1, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, Index'(1), e3, 1'b0, 1'b0, 1'b0, '0);
        tick();
        check_outs("arst_pre", 1'b1, Index'(1), Prio'(3), DW'(1), '0);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("arst", 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Randomized stimulus against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            drive(1'($urandom_range(0, 1)), Index'($urandom_range(0, 2)), Entries'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 19) == 0), Prio'($urandom));
            model_step();
            tick();
            check_outs($sformatf("rnd%0d", c), m_req, Index'(m_id), Prio'(m_thr),
                       DW'(m_stk.size()), SrcMask'(m_pclr));
`ifdef CAN_CLIC_STACK_ERR_EN
            check($sformatf("rnd%0d.stack_err", c), 32'(stack_err), 32'(m_err));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
